// File: rtl/cla_pkg.sv
// Shared constants and types for the carry-look-ahead adder slice.
package cla_pkg;

    localparam int unsigned BLOCK_W       = 4;
    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // Group generate / propagate exported by one lookahead block
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage : cla_pkg

// File: rtl/cla_adder_32_if.sv
// Operand / result bundle for cla_adder_32.
// Optional feature macro: CLA_ADDER_OVF_EN adds the signed-overflow flag.
interface cla_adder_32_if
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_ADDER_OVF_EN
    logic             ovf;

    modport master (output a, output b, output cin, input sum, input cout, input ovf);
    modport slave  (input a, input b, input cin, output sum, output cout, output ovf);
`else
    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
`endif

endinterface : cla_adder_32_if

// File: rtl/cla_block4.sv
// 4-bit carry-look-ahead block: local carries, sum bits and group G/P.
module cla_block4
    import cla_pkg::*;
(
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               ci,
    output logic [BLOCK_W-1:0] s,
    output gp_t                gp
);

    logic [BLOCK_W-1:0] g;
    logic [BLOCK_W-1:0] p;
    logic [BLOCK_W-1:0] c;

    // Bit and group generate/propagate; independent of the carry-in
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        gp.g = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        gp.p = &p;
    end

    // Flattened internal carries and sum bits
    always_comb begin
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
    end

endmodule : cla_block4

// File: rtl/cla_adder_32.sv
// Registered two-level carry-look-ahead adder: {cout, sum} <= a + b + cin.
// Optional feature macro: CLA_ADDER_OVF_EN adds a registered signed-overflow flag.
module cla_adder_32
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
)(
    input  logic           clk,
    input  logic           rst_n,
    cla_adder_32_if.slave  bus
);

    localparam int unsigned NBLK = WIDTH / BLOCK_W;

    gp_t              gp [NBLK];
    logic [NBLK:0]    bc;
    logic [WIDTH-1:0] sum_next;

    // One lookahead block per nibble
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        cla_block4 u_blk (
            .a  (bus.a[k*BLOCK_W +: BLOCK_W]),
            .b  (bus.b[k*BLOCK_W +: BLOCK_W]),
            .ci (bc[k]),
            .s  (sum_next[k*BLOCK_W +: BLOCK_W]),
            .gp (gp[k])
        );
    end

    // Group lookahead: every block carry-in as a flat sum of products from cin
    always_comb begin
        logic c_acc;
        logic p_run;
        bc    = '0;
        c_acc = 1'b0;
        p_run = 1'b1;
        bc[0] = bus.cin;
        for (int k = 1; k <= int'(NBLK); k++) begin
            c_acc = 1'b0;
            for (int j = 0; j < k; j++) begin
                p_run = 1'b1;
                for (int m = j + 1; m < k; m++) begin
                    p_run = p_run & gp[m].p;
                end
                c_acc = c_acc | (gp[j].g & p_run);
            end
            p_run = 1'b1;
            for (int m = 0; m < k; m++) begin
                p_run = p_run & gp[m].p;
            end
            bc[k] = c_acc | (bus.cin & p_run);
        end
    end

`ifdef CLA_ADDER_OVF_EN
    logic ovf_next;

    // Like-signed operands producing an opposite-signed result
    always_comb begin
        ovf_next = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum_next[WIDTH-1] != bus.a[WIDTH-1]);
    end

    // Overflow flag register, aligned with sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf <= 1'b0;
        end else begin
            bus.ovf <= ovf_next;
        end
    end
`endif

    // Result registers; reset clears them immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= sum_next;
            bus.cout <= bc[NBLK];
        end
    end

endmodule : cla_adder_32

// File: tb/tb_cla_adder_32.sv
// Scoreboard bench for cla_adder_32 against an arithmetic reference model.
module tb_cla_adder_32;
    import cla_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    bit     mon_en = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;
    exp_t   q[$];

    always #5 clk = ~clk;

    cla_adder_32_if #(.WIDTH(W)) bus ();

    cla_adder_32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: plain wide-integer arithmetic
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t            e;
        longint unsigned ua, ub, ut;
        longint          sa, sb, st;
        ua   = a;
        ub   = b;
        ut   = ua + ub + longint'(ci);
        sa   = $signed(a);
        sb   = $signed(b);
        st   = sa + sb + longint'(ci);
        e.a  = a;
        e.b  = b;
        e.ci = ci;
        e.s  = ut[W-1:0];
        e.co = ut[W];
        e.ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic get_ovf();
`ifdef CLA_ADDER_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
        q.push_back(model(a, b, ci));
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        push_vec(a, b, ci);
    endtask

    task automatic check_reset(input string tag);
        logic ov;
        ov = get_ovf();
        n_vec++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b, expected all zero", tag, bus.sum, bus.cout, ov);
        end
    endtask

    // Monitor: every cycle's result is compared with the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        logic ok;
        logic ov;
        #1;
        if (mon_en && rst_n && q.size() > 0) begin
            e  = q.pop_front();
            ov = get_ovf();
            ok = (bus.sum === e.s) && (bus.cout === e.co);
`ifdef CLA_ADDER_OVF_EN
            ok = ok && (ov === e.ov);
`endif
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL add a=%h b=%h cin=%b: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         e.a, e.b, e.ci, bus.sum, bus.cout, ov, e.s, e.co, e.ov);
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        rst_n   = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_state");

        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed cases, back-to-back
        drive(32'h00000001, 32'h00000002, 1'b0);
        drive(32'h00000006, 32'h00000005, 1'b1);
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0);
        drive(32'h80000000, 32'h80000000, 1'b1);
        drive(32'h12345678, 32'h87654321, 1'b0);
        drive(32'hAAAAAAAA, 32'h55555555, 1'b1);
        drive(32'h7FFFFFFF, 32'h00000000, 1'b1);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        drive(32'h00000000, 32'h00000000, 1'b0);

        // Randomized, biased toward long carry chains and sign boundaries
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                1: rb = ~ra;
                2: begin ra = 32'hFFFFFFFF - 32'($urandom_range(0, 3)); rb = 32'($urandom_range(0, 3)); end
                3: begin ra = {1'b0, ra[W-2:0]} | 32'h7FFF0000; rb = {ra[W-1], rb[W-2:0]}; end
                default: ;
            endcase
            drive(ra, rb, rc);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
            q.delete();
        end

        // Asynchronous reset while the result is nonzero
        drive(32'h80000000, 32'h80000000, 1'b1);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #1;
        check_reset("reset_held");

        // First edge after release loads a fresh result
        @(negedge clk);
        rst_n  = 1'b1;
        q.delete();
        push_vec(32'h0000FFFF, 32'h00000001, 1'b0);
        mon_en = 1'b1;
        drive(32'hFFFFFFFF, 32'h00000000, 1'b1);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL post_reset_drain: got %0d pending results, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cla_adder_32
